// File: rtl/braid_seq_pkg.sv
// ============================================================================
// Module : braid_seq_pkg
// Brief  : Shared state encoding and run-length helper for the braid sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package braid_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    XFER  = 3'd2,
    MIX   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Clocks from the first FILL cycle to the last DRAIN cycle of an unaborted run.
  function automatic int run_length(input int depth, input int fill_cycles,
                                    input int mix_cycles);
    return 2 * fill_cycles + depth * (fill_cycles + mix_cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/braid_mix_sequencer_if.sv
// ============================================================================
// Module : braid_mix_sequencer_if
// Brief  : Controller-to-sequencer bundle; pause exists only with BRAID_SEQ_PAUSE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface braid_mix_sequencer_if #(
  parameter int N_CH  = 16,
  parameter int DEPTH = 4
);
  localparam int SW = $clog2(DEPTH) + 1;

  logic              start;
  logic              abort;
  logic [N_CH-1:0]   ch_mask;
`ifdef BRAID_SEQ_PAUSE_EN
  logic              pause;
`endif
  logic [N_CH-1:0]   inlet_valve;
  logic [DEPTH-1:0]  stage_valve;
  logic [DEPTH-1:0]  mix_pump;
  logic              outlet_valve;
  logic [SW-1:0]     stage_idx;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
`ifdef BRAID_SEQ_PAUSE_EN
    output pause,
`endif
    output start, abort, ch_mask,
    input  inlet_valve, stage_valve, mix_pump, outlet_valve,
    input  stage_idx, busy, done, err
  );

  modport slave (
`ifdef BRAID_SEQ_PAUSE_EN
    input  pause,
`endif
    input  start, abort, ch_mask,
    output inlet_valve, stage_valve, mix_pump, outlet_valve,
    output stage_idx, busy, done, err
  );

endinterface

`default_nettype wire

// File: rtl/braid_phase_timer.sv
// ============================================================================
// Module : braid_phase_timer
// Brief  : Loadable down-counter that flags when the current phase has run out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module braid_phase_timer #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic             hold,
  input  wire logic [CNT_W-1:0] load_val,
  output      logic             expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (!hold && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/braid_mix_sequencer.sv
// ============================================================================
// Module : braid_mix_sequencer
// Brief  : Valve/pump sequencer: FILL, XFER/MIX per stage, DRAIN, DONE.
//          Optional pause input enabled by macro BRAID_SEQ_PAUSE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module braid_mix_sequencer
  import braid_seq_pkg::*;
#(
  parameter int N_CH        = 16,
  parameter int DEPTH       = 4,
  parameter int FILL_CYCLES = 4,
  parameter int MIX_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input wire logic              clk,
  input wire logic              rst_n,
  braid_mix_sequencer_if.slave  bus
);

  localparam int               SW         = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIX_LOAD   = CNT_W'(MIX_CYCLES - 1);
  localparam logic [SW-1:0]    LAST_STAGE = SW'(DEPTH - 1);

  generate
    if (N_CH < 2 || DEPTH < 1 || FILL_CYCLES < 1 || MIX_CYCLES < 1) begin : g_bad_shape
      $error("braid_mix_sequencer: N_CH>=2, DEPTH>=1, FILL_CYCLES>=1, MIX_CYCLES>=1");
    end
    if ((longint'(FILL_CYCLES) >= (longint'(1) << CNT_W)) ||
        (longint'(MIX_CYCLES)  >= (longint'(1) << CNT_W))) begin : g_bad_cnt_w
      $error("braid_mix_sequencer: CNT_W too narrow for phase lengths");
    end
  endgenerate

  state_t           state, nxt_state;
  logic [SW-1:0]    stage, nxt_stage;
  logic [N_CH-1:0]  mask, nxt_mask;
  logic             err_flag, nxt_err;
  logic             tmr_load, tmr_hold, tmr_expired, paused;
  logic [CNT_W-1:0] tmr_val;

  braid_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .hold     (tmr_hold),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    nxt_state = state;
    nxt_stage = stage;
    nxt_mask  = mask;
    nxt_err   = err_flag;
    tmr_load  = 1'b0;
    tmr_hold  = 1'b0;
    tmr_val   = FILL_LOAD;
    paused    = 1'b0;
    case (state)
      IDLE: begin
        nxt_stage = '0;
        // A simultaneous abort swallows the start request.
        if (bus.start && !bus.abort) begin
          if (|bus.ch_mask) begin
            nxt_state = FILL;
            nxt_mask  = bus.ch_mask;
            nxt_err   = 1'b0;
            tmr_load  = 1'b1;
          end else begin
            nxt_state = DONE;
            nxt_err   = 1'b1;
          end
        end
      end
      FILL, XFER, MIX: begin
        if (bus.abort) begin
          nxt_state = DRAIN;
          nxt_stage = '0;
          nxt_err   = 1'b1;
          tmr_load  = 1'b1;
        end
`ifdef BRAID_SEQ_PAUSE_EN
        else if (bus.pause) begin
          tmr_hold = 1'b1;
          paused   = 1'b1;
        end
`endif
        else if (tmr_expired) begin
          tmr_load = 1'b1;
          if (state == FILL) begin
            nxt_state = XFER;
            nxt_stage = '0;
          end else if (state == XFER) begin
            nxt_state = MIX;
            tmr_val   = MIX_LOAD;
          end else if (stage == LAST_STAGE) begin
            nxt_state = DRAIN;
            nxt_stage = '0;
          end else begin
            nxt_state = XFER;
            nxt_stage = stage + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (tmr_expired) begin
          nxt_state = DONE;
        end
      end
      DONE: begin
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
        nxt_stage = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      stage            <= '0;
      mask             <= '0;
      err_flag         <= 1'b0;
      bus.inlet_valve  <= '0;
      bus.stage_valve  <= '0;
      bus.mix_pump     <= '0;
      bus.outlet_valve <= 1'b0;
      bus.stage_idx    <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      state            <= nxt_state;
      stage            <= nxt_stage;
      mask             <= nxt_mask;
      err_flag         <= nxt_err;
      bus.inlet_valve  <= (nxt_state == FILL && !paused) ? nxt_mask : '0;
      bus.stage_valve  <= (nxt_state == XFER && !paused) ? (DEPTH'(1) << nxt_stage) : '0;
      bus.mix_pump     <= (nxt_state == MIX && !paused) ? (DEPTH'(1) << nxt_stage) : '0;
      bus.outlet_valve <= (nxt_state == DRAIN);
      bus.stage_idx    <= (nxt_state == XFER || nxt_state == MIX) ? nxt_stage : '0;
      bus.busy         <= (nxt_state != IDLE) && (nxt_state != DONE);
      bus.done         <= (nxt_state == DONE);
      bus.err          <= (nxt_state == DONE) && nxt_err;
    end
  end

endmodule

`default_nettype wire
